// File: rtl/handshake_rx_buffer.sv
// handshake_rx_buffer
// Destination-domain receiver for the CDC handshake synchronizer. It captures
// each data-valid strobe and its word into a small first-word-fall-through
// FIFO and presents the words through a valid/ready interface. A word that
// arrives while the FIFO is full with no pop is dropped, and the sticky
// OVERFLOW_O flag records the loss.
// Optional feature macro: HANDSHAKE_RX_EDGE_DET_EN -- treat SYNC_PULSE_I as a
// level and push only on its 0->1 transition.
module handshake_rx_buffer #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_DEPTH      = 4
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic [C_DATA_WIDTH-1:0]   SYNC_DATA_I,
    input  logic                      SYNC_PULSE_I,
    output logic [C_DATA_WIDTH-1:0]   DATA_O,
    output logic                      VALID_O,
    input  logic                      READY_I,
    output logic [$clog2(C_DEPTH):0]  LEVEL_O,
    output logic                      OVERFLOW_O,
    input  logic                      CLR_OVF_I
);

    localparam int AW = $clog2(C_DEPTH);
    localparam int LW = AW + 1;

    logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LW-1:0]           level;
    logic                    ovf;

    logic push_req;
    logic full;
    logic pop;
    logic push_acc;
    logic push_drop;

`ifdef HANDSHAKE_RX_EDGE_DET_EN
    logic pulse_q;

    // Remember the previous request level so a held request pushes only once
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= SYNC_PULSE_I;
        end
    end

    assign push_req = SYNC_PULSE_I & ~pulse_q;
`else
    assign push_req = SYNC_PULSE_I;
`endif

    // Decide pop, push acceptance and drop from the registered occupancy
    always_comb begin
        full      = (level == LW'(C_DEPTH));
        pop       = (level != '0) & READY_I;
        push_acc  = push_req & (~full | pop);
        push_drop = push_req & full & ~pop;
    end

    // Advance pointers and occupancy; pointers wrap naturally at C_DEPTH
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_acc, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Store accepted words; contents need no reset since DATA_O is gated
    always_ff @(posedge CLK_I) begin
        if (push_acc) begin
            mem[wr_ptr] <= SYNC_DATA_I;
        end
    end

    // Sticky overflow flag; a new drop outranks a simultaneous clear
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ovf <= 1'b0;
        end else if (push_drop) begin
            ovf <= 1'b1;
        end else if (CLR_OVF_I) begin
            ovf <= 1'b0;
        end
    end

    assign VALID_O    = (level != '0);
    assign LEVEL_O    = level;
    assign DATA_O     = VALID_O ? mem[rd_ptr] : '0;
    assign OVERFLOW_O = ovf;

endmodule
